wb_writer: RTL and testbench

Write-back unit that owns the register-file write port (`port3_in`/`data_in` of the core register file). It collects ALU results and load completions, aligns and sign/zero-extends load data, serialises everything through a small write FIFO, and emits at most one register write per cycle. It also tells decode which destination registers still have writes outstanding, so decode can stall on read-after-write hazards.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_writer_if.sv | 34 +++
 rtl/wb_writer_load_align.sv | 31 +++
 rtl/wb_writer.sv | 118 +++++++++++
 tb/tb_wb_writer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back unit: load funct3 encodings,
// the write-FIFO entry layout and the hard-wired zero register index.
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_writer_if.sv
// Bundle of all wb_writer handshake and data signals.
//   slave  : the write-back unit itself (drives readies, query hit, rd/data out)
//   master : the core side (ALU, load issue, memory return, decode query)
interface wb_writer_if;
  logic        alu_valid_in;
  logic [4:0]  alu_rd_in;
  logic [31:0] alu_data_in;
  logic        alu_ready_out;
  logic        ld_valid_in;
  logic [4:0]  ld_rd_in;
  logic [2:0]  ld_funct3_in;
  logic [1:0]  ld_addr_lo_in;
  logic        ld_ready_out;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  logic [4:0]  query_rd_in;
  logic        query_hit_out;
  logic [4:0]  rd_out;
  logic [31:0] data_out;

  modport slave (
    input  alu_valid_in, alu_rd_in, alu_data_in,
    input  ld_valid_in, ld_rd_in, ld_funct3_in, ld_addr_lo_in,
    input  mem_rvalid_in, mem_rdata_in, query_rd_in,
    output alu_ready_out, ld_ready_out, query_hit_out, rd_out, data_out
  );

  modport master (
    output alu_valid_in, alu_rd_in, alu_data_in,
    output ld_valid_in, ld_rd_in, ld_funct3_in, ld_addr_lo_in,
    output mem_rvalid_in, mem_rdata_in, query_rd_in,
    input  alu_ready_out, ld_ready_out, query_hit_out, rd_out, data_out
  );
endinterface

// File: rtl/wb_writer_load_align.sv
// load_align: picks the addressed byte/halfword out of a raw aligned memory
// word and sign- or zero-extends it. Purely combinational.
//   funct3  : load type
//   addr_lo : address bits [1:0]
//   word    : raw memory word
//   data    : formatted 32-bit register value
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word >> {addr_lo, 3'b000});
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = word;  // LW and reserved encodings
    endcase
  end

endmodule

// File: rtl/wb_writer.sv
// wb_writer: owns the register-file write port. Merges load completions and
// ALU results into a small write FIFO and retires one write per cycle.
// Also reports whether a register still has a write outstanding.
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_writer_if.slave (ALU/load/memory inputs, readies,
//              query hit, rd_out/data_out register-file write)
module wb_writer
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  wb_writer_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     fifo_q [DEPTH];
  wb_entry_t     fifo_d [DEPTH];
  logic [CW-1:0] count_q, count_d;

  logic        pend_v;
  logic [4:0]  pend_rd;
  logic [2:0]  pend_f3;
  logic [1:0]  pend_lo;
  logic [31:0] ld_data;

  logic [4:0]  rd_q;
  logic [31:0] data_q;
  wb_entry_t   out_d;

  logic ld_acc, ld_done, alu_acc;

  load_align u_align (
    .funct3  (pend_f3),
    .addr_lo (pend_lo),
    .word    (bus.mem_rdata_in),
    .data    (ld_data)
  );

  // Two slots are always free when ALU is ready, so a load completion
  // arriving in the same cycle can never be refused.
  assign bus.alu_ready_out = (count_q <= CW'(DEPTH - 2));
  assign bus.ld_ready_out  = !pend_v;
  assign bus.rd_out        = rd_q;
  assign bus.data_out      = data_q;

  assign ld_acc  = bus.ld_valid_in && !pend_v;
  assign ld_done = pend_v && bus.mem_rvalid_in;
  assign alu_acc = bus.alu_valid_in && bus.alu_ready_out;

  // Stage = current entries followed by this cycle's pushes (load first).
  // Element 0 goes out; the rest shift down into the FIFO. This also gives
  // the empty-FIFO bypass straight to rd_out.
  always_comb begin
    wb_entry_t     stage [DEPTH+1];
    logic [CW-1:0] n;
    for (int i = 0; i < DEPTH + 1; i++) stage[i] = '0;
    for (int i = 0; i < DEPTH; i++) stage[i] = fifo_q[i];
    n = count_q;
    if (ld_done && pend_rd != REG_ZERO) begin
      stage[n] = '{rd: pend_rd, data: ld_data};
      n = n + CW'(1);
    end
    if (alu_acc && bus.alu_rd_in != REG_ZERO) begin
      stage[n] = '{rd: bus.alu_rd_in, data: bus.alu_data_in};
      n = n + CW'(1);
    end
    for (int i = 0; i < DEPTH; i++) fifo_d[i] = stage[i+1];
    if (n != '0) begin
      out_d   = stage[0];
      count_d = n - CW'(1);
    end else begin
      out_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      pend_v  <= 1'b0;
      pend_rd <= '0;
      pend_f3 <= '0;
      pend_lo <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      fifo_q  <= fifo_d;
      count_q <= count_d;
      rd_q    <= out_d.rd;
      data_q  <= out_d.data;
      if (ld_acc) begin
        pend_v  <= 1'b1;
        pend_rd <= bus.ld_rd_in;
        pend_f3 <= bus.ld_funct3_in;
        pend_lo <= bus.ld_addr_lo_in;
      end else if (ld_done) begin
        pend_v  <= 1'b0;
      end
    end
  end

  // rd_q is included because the register file only sees it next cycle.
  always_comb begin
    bus.query_hit_out = 1'b0;
    if (bus.query_rd_in != REG_ZERO) begin
      if (pend_v && pend_rd == bus.query_rd_in) bus.query_hit_out = 1'b1;
      if (rd_q == bus.query_rd_in) bus.query_hit_out = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < count_q && fifo_q[i].rd == bus.query_rd_in)
          bus.query_hit_out = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_writer.sv
module tb_wb_writer;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  wb_writer_if bus();

  wb_writer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] word;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t   lv [10];
  wb_entry_t exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid_in  = 1'b0;
    bus.alu_rd_in     = '0;
    bus.alu_data_in   = '0;
    bus.ld_valid_in   = 1'b0;
    bus.ld_rd_in      = '0;
    bus.ld_funct3_in  = '0;
    bus.ld_addr_lo_in = '0;
    bus.mem_rvalid_in = 1'b0;
    bus.mem_rdata_in  = '0;
    bus.query_rd_in   = '0;
  endtask

  initial begin
    logic        m_pend;
    logic [4:0]  m_pend_rd;
    int          ld_n, alu_n;
    logic        saw_stall, m_alu_rdy;
    logic [31:0] word;

    lv[0] = '{F3_LB,  2'd2, 32'h0080_FF11, 32'hFFFF_FF80};
    lv[1] = '{F3_LBU, 2'd2, 32'h0080_FF11, 32'h0000_0080};
    lv[2] = '{F3_LH,  2'd2, 32'h0080_FF11, 32'h0000_0080};
    lv[3] = '{F3_LHU, 2'd0, 32'h0000_FF11, 32'h0000_FF11};
    lv[4] = '{F3_LH,  2'd0, 32'h0000_FF11, 32'hFFFF_FF11};
    lv[5] = '{F3_LB,  2'd1, 32'h0080_FF11, 32'hFFFF_FFFF};
    lv[6] = '{F3_LHU, 2'd3, 32'h8001_1234, 32'h0000_8001};
    lv[7] = '{F3_LW,  2'd1, 32'hCAFE_BABE, 32'hCAFE_BABE};
    lv[8] = '{3'b011, 2'd2, 32'h1234_5678, 32'h1234_5678};
    lv[9] = '{F3_LB,  2'd3, 32'h7F00_0000, 32'h0000_007F};

    idle_inputs();
    bus.query_rd_in = 5'd5;
    tick();
    chk("reset rd_out", bus.rd_out, 0);
    chk("reset data_out", bus.data_out, 0);
    chk("reset alu_ready", bus.alu_ready_out, 1);
    chk("reset ld_ready", bus.ld_ready_out, 1);
    chk("reset query_hit", bus.query_hit_out, 0);
    tick();
    rst = 1'b0;

    // ALU single write and one-cycle latency
    tick();
    tick();
    bus.alu_valid_in = 1'b1;
    bus.alu_rd_in    = 5'd5;
    bus.alu_data_in  = 32'h1234_5678;
    tick();
    bus.alu_valid_in = 1'b0;
    chk("alu rd_out", bus.rd_out, 5);
    chk("alu data_out", bus.data_out, 32'h1234_5678);
    chk("alu query rd_out hit", bus.query_hit_out, 1);
    tick();
    chk("alu rd_out idle", bus.rd_out, 0);
    chk("alu query clear", bus.query_hit_out, 0);

    // Load formatting table
    for (int i = 0; i < 10; i++) begin
      bus.ld_valid_in   = 1'b1;
      bus.ld_rd_in      = 5'd7;
      bus.ld_funct3_in  = lv[i].f3;
      bus.ld_addr_lo_in = lv[i].lo;
      tick();
      bus.ld_valid_in   = 1'b0;
      chk($sformatf("vec%0d ld_ready pending", i), bus.ld_ready_out, 0);
      bus.mem_rvalid_in = 1'b1;
      bus.mem_rdata_in  = lv[i].word;
      tick();
      bus.mem_rvalid_in = 1'b0;
      chk($sformatf("vec%0d rd_out", i), bus.rd_out, 7);
      chk($sformatf("vec%0d data_out", i), bus.data_out, lv[i].exp);
      chk($sformatf("vec%0d ld_ready done", i), bus.ld_ready_out, 1);
    end
    tick();
    chk("ld idle rd_out", bus.rd_out, 0);

    // Same-cycle load completion and ALU result
    bus.ld_valid_in  = 1'b1;
    bus.ld_rd_in     = 5'd3;
    bus.ld_funct3_in = F3_LW;
    tick();
    bus.ld_valid_in  = 1'b0;
    bus.query_rd_in  = 5'd3;
    #1;
    chk("pend query hit", bus.query_hit_out, 1);
    bus.mem_rvalid_in = 1'b1;
    bus.mem_rdata_in  = 32'hDEAD_BEEF;
    bus.alu_valid_in  = 1'b1;
    bus.alu_rd_in     = 5'd4;
    bus.alu_data_in   = 32'h1;
    tick();
    bus.mem_rvalid_in = 1'b0;
    bus.alu_valid_in  = 1'b0;
    bus.query_rd_in   = 5'd4;
    chk("dual first rd", bus.rd_out, 3);
    chk("dual first data", bus.data_out, 32'hDEAD_BEEF);
    #1;
    chk("dual fifo query hit", bus.query_hit_out, 1);
    tick();
    chk("dual second rd", bus.rd_out, 4);
    chk("dual second data", bus.data_out, 32'h1);
    chk("dual out query hit", bus.query_hit_out, 1);
    tick();
    chk("dual idle rd", bus.rd_out, 0);
    chk("dual query clear", bus.query_hit_out, 0);

    // ALU writes to x0 are dropped
    bus.alu_valid_in = 1'b1;
    bus.alu_rd_in    = 5'd0;
    bus.query_rd_in  = 5'd0;
    for (int i = 0; i < 10; i++) begin
      bus.alu_data_in = 32'hF00 + i;
      tick();
      chk("x0 rd_out", bus.rd_out, 0);
      chk("x0 alu_ready", bus.alu_ready_out, 1);
    end
    bus.alu_valid_in = 1'b0;
    tick();

    // Sustained ALU traffic plus back-to-back loads: scoreboard order check
    m_pend = 1'b0; m_pend_rd = '0; ld_n = 0; alu_n = 0; saw_stall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.alu_valid_in  = (c < 24);
      bus.alu_rd_in     = 5'(1 + alu_n % 15);
      bus.alu_data_in   = 32'h1000_0000 + alu_n;
      bus.ld_valid_in   = (c < 24);
      bus.ld_rd_in      = 5'(16 + ld_n % 15);
      bus.ld_funct3_in  = F3_LW;
      bus.ld_addr_lo_in = 2'd0;
      bus.mem_rvalid_in = 1'b1;
      word = 32'hA000_0000 + ld_n;
      bus.mem_rdata_in  = word;
      m_alu_rdy = (exp_q.size() <= 2);
      if (!m_alu_rdy) saw_stall = 1'b1;
      #1;
      chk($sformatf("stream c%0d alu_ready", c), bus.alu_ready_out, m_alu_rdy);
      chk($sformatf("stream c%0d ld_ready", c), bus.ld_ready_out, !m_pend);
      if (m_pend) begin
        exp_q.push_back('{rd: m_pend_rd, data: word});
        m_pend = 1'b0;
        ld_n++;
      end else if (bus.ld_valid_in) begin
        m_pend    = 1'b1;
        m_pend_rd = bus.ld_rd_in;
      end
      if (bus.alu_valid_in && m_alu_rdy) begin
        exp_q.push_back('{rd: bus.alu_rd_in, data: bus.alu_data_in});
        alu_n++;
      end
      tick();
      if (exp_q.size() > 0) begin
        chk($sformatf("stream c%0d rd", c), bus.rd_out, exp_q[0].rd);
        chk($sformatf("stream c%0d data", c), bus.data_out, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        chk($sformatf("stream c%0d idle rd", c), bus.rd_out, 0);
      end
    end
    chk("stream drained", exp_q.size(), 0);
    chk("stream alu stalled", saw_stall, 1);
    idle_inputs();
    tick();

    // Reset mid-operation: fill FIFO, leave a load pending, then reset
    bus.alu_valid_in = 1'b1; bus.alu_rd_in = 5'd10; bus.alu_data_in = 32'h10;
    bus.ld_valid_in  = 1'b1; bus.ld_rd_in  = 5'd11; bus.ld_funct3_in = F3_LW;
    tick();
    bus.ld_valid_in  = 1'b0; bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'h11;
    bus.alu_rd_in = 5'd12; bus.alu_data_in = 32'h12;
    tick();
    bus.mem_rvalid_in = 1'b0; bus.ld_valid_in = 1'b1; bus.ld_rd_in = 5'd13;
    bus.alu_rd_in = 5'd14; bus.alu_data_in = 32'h14;
    tick();
    bus.ld_valid_in  = 1'b0; bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'h13;
    bus.alu_rd_in = 5'd15; bus.alu_data_in = 32'h15;
    tick();
    bus.mem_rvalid_in = 1'b0; bus.ld_valid_in = 1'b1; bus.ld_rd_in = 5'd17;
    bus.alu_rd_in = 5'd16; bus.alu_data_in = 32'h16;
    tick();
    bus.ld_valid_in  = 1'b0; bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'h17;
    bus.alu_rd_in = 5'd18; bus.alu_data_in = 32'h18;
    tick();
    bus.alu_valid_in = 1'b0; bus.mem_rvalid_in = 1'b0;
    chk("fill count3 alu_ready", bus.alu_ready_out, 0);
    bus.ld_valid_in = 1'b1; bus.ld_rd_in = 5'd19;
    tick();
    bus.ld_valid_in = 1'b0;
    bus.query_rd_in = 5'd19;
    #1;
    chk("fill pend ld_ready", bus.ld_ready_out, 0);
    chk("fill pend query", bus.query_hit_out, 1);
    rst = 1'b1;
    bus.alu_valid_in = 1'b1; bus.alu_rd_in = 5'd20; bus.alu_data_in = 32'h20;
    bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'h19;
    tick();
    rst = 1'b0;
    bus.alu_valid_in = 1'b0;
    chk("rst rd_out", bus.rd_out, 0);
    chk("rst ld_ready", bus.ld_ready_out, 1);
    chk("rst alu_ready", bus.alu_ready_out, 1);
    chk("rst query pend", bus.query_hit_out, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.mem_rvalid_in = 1'b0;
      bus.query_rd_in = 5'd18;
      chk($sformatf("post rst c%0d rd_out", i), bus.rd_out, 0);
      #1;
      chk($sformatf("post rst c%0d query", i), bus.query_hit_out, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
